// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Register-file write-port arbiter. ALU writes always win; load
//            writebacks wait in a small FIFO that ALU writes can kill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_we,
  input  logic [4:0]               alu_waddr,
  input  logic [31:0]              alu_wdata,
  input  logic                     lsu_valid,
  input  logic [4:0]               lsu_waddr,
  input  logic [31:0]              lsu_wdata,
  output logic                     lsu_ready,
  output logic                     we,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX  = AW'(STARVE_LIMIT);

  logic              vld_q  [DEPTH];
  logic              vld_d  [DEPTH];
  logic [4:0]        addr_q [DEPTH];
  logic [4:0]        addr_d [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     age_q, age_d;
  logic              we_q, we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              stall_q, stall_d;

  logic              alu_acc;
  logic              push;
  logic              pop;

  assign lsu_ready  = (count_q < FULL_CNT);
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign stall_req  = stall_q;
  assign fifo_count = count_q;

  always_comb begin
    alu_acc  = alu_we && (alu_waddr != 5'd0);
    push     = lsu_valid && lsu_ready && (lsu_waddr != 5'd0);
    // The head is sampled from current state, so a same-cycle push never pops.
    pop      = !alu_acc && (count_q != '0);

    vld_d    = vld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    age_d    = age_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    stall_d  = (count_q == FULL_CNT) || (age_q >= AGE_MAX);

    if (alu_acc) begin
      we_d    = 1'b1;
      waddr_d = alu_waddr;
      wdata_d = alu_wdata;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == alu_waddr) vld_d[i] = 1'b0;
      end
    end else if (pop) begin
      we_d = vld_q[rd_ptr_q];
      if (vld_q[rd_ptr_q]) begin
        waddr_d = addr_q[rd_ptr_q];
        wdata_d = data_q[rd_ptr_q];
      end
    end

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end

    // Applied after the kill loop: the pushed load is younger than the ALU write.
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      addr_d[wr_ptr_q] = lsu_waddr;
      data_d[wr_ptr_q] = lsu_wdata;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if ((count_q == '0) || pop) begin
      age_d = '0;
    end else if (age_q < AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      stall_q  <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      stall_q  <= stall_d;
    end
  end

endmodule

`default_nettype wire
